// File: rtl/demo_counter_pkg.sv
// Shared constants and types for the demo counter step sequencer.
package demo_counter_pkg;

    localparam int              CNT_W   = 20;
    localparam logic [19:0]     CNT_MAX = 20'hfffff;

    // Magic values the counter must land on exactly; MAGIC[0] is the lowest.
    localparam logic [3:0][19:0] MAGIC = {20'd456789, 20'd345678, 20'd234567, 20'd123456};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        ISSUE  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/demo_counter_step_ctrl_if.sv
// Increment handshake between the step sequencer (master) and the counter datapath (slave).
interface demo_counter_step_ctrl_if #(
    parameter int SW = 5
);
    logic          inc_valid;
    logic [SW-1:0] inc_amount;
    logic          inc_ready;

    modport master (output inc_valid, output inc_amount, input  inc_ready);
    modport slave  (input  inc_valid, input  inc_amount, output inc_ready);
endinterface

// File: rtl/demo_counter_next_bound.sv
// Distance from the live counter value to the next value it must not skip:
// the nearest magic value above it, or the all-ones maximum. At the maximum
// the only legal move is the single step that wraps to zero.
module demo_counter_next_bound
    import demo_counter_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] i_counter,
    output logic [WIDTH-1:0] o_dist_b
);

    logic [WIDTH-1:0] w_cand [5];
    logic [WIDTH-1:0] w_min;

    // One candidate per magic value; magic values at or below the counter are out of reach.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_magic
            assign w_cand[gi] = (WIDTH'(MAGIC[gi]) > i_counter) ? (WIDTH'(MAGIC[gi]) - i_counter) : '1;
        end
    endgenerate

    // Maximum value as the final bound; at the maximum the bound is the wrap to zero.
    assign w_cand[4] = (i_counter == '1) ? WIDTH'(1) : ('1 - i_counter);

    // Smallest candidate wins.
    always_comb begin
        w_min = w_cand[4];
        for (int i = 0; i < 4; i++) begin
            if (w_cand[i] < w_min) begin
                w_min = w_cand[i];
            end
        end
    end

    assign o_dist_b = w_min;

endmodule

// File: rtl/demo_counter_step_ctrl.sv
// Step sequencer: walks the demo counter to a requested target through bounded
// increments, never skipping a magic value and only overflowing through the maximum.
module demo_counter_step_ctrl
    import demo_counter_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int MAX_STEP = 16,
    parameter int SW       = 5
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [WIDTH-1:0]          i_target,
    input  logic [SW-1:0]             i_step_req,
    input  logic                      i_abort,
    input  logic [WIDTH-1:0]          i_counter,
    demo_counter_step_ctrl_if.master  if_inc,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [3:0]                o_magic_hit,
    output logic                      o_error
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_CALC   = CALC;
    localparam logic [2:0] ST_ISSUE  = ISSUE;
    localparam logic [2:0] ST_SETTLE = SETTLE;
    localparam logic [2:0] ST_DONE   = DONE;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_target;
    logic [SW-1:0]    r_step;
    logic [WIDTH-1:0] r_expected;
    logic             r_abort;
    logic             r_inc_valid;
    logic [SW-1:0]    r_inc_amount;
    logic [3:0]       r_magic_hit;
    logic             r_error;

    logic [WIDTH-1:0] w_dist_b;
    logic [WIDTH-1:0] w_dist_t;
    logic [WIDTH-1:0] w_min_amt;
    logic [SW-1:0]    w_step_norm;
    logic [3:0]       w_magic_eq;
    logic             w_handshake;
    logic             w_abort_seen;

    demo_counter_next_bound #(.WIDTH(WIDTH)) u_next_bound (
        .i_counter (i_counter),
        .o_dist_b  (w_dist_b)
    );

    assign w_dist_t     = r_target - i_counter;
    assign w_handshake  = r_inc_valid & if_inc.inc_ready;
    assign w_abort_seen = r_abort | i_abort;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_magic_eq
            assign w_magic_eq[gi] = (i_counter == WIDTH'(MAGIC[gi]));
        end
    endgenerate

    // Requested step clamped into 1..MAX_STEP.
    always_comb begin
        w_step_norm = i_step_req;
        if (i_step_req == '0) begin
            w_step_norm = SW'(1);
        end else if (i_step_req > SW'(MAX_STEP)) begin
            w_step_norm = SW'(MAX_STEP);
        end
    end

    // Increment size: smallest of nominal step, distance to bound, distance to target.
    always_comb begin
        w_min_amt = WIDTH'(r_step);
        if (w_dist_b < w_min_amt) begin
            w_min_amt = w_dist_b;
        end
        if (w_dist_t < w_min_amt) begin
            w_min_amt = w_dist_t;
        end
    end

    // Sequencer state machine and all registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_target     <= '0;
            r_step       <= '0;
            r_expected   <= '0;
            r_abort      <= 1'b0;
            r_inc_valid  <= 1'b0;
            r_inc_amount <= '0;
            r_magic_hit  <= '0;
            r_error      <= 1'b0;
        end else begin
            r_magic_hit <= '0;
            if (i_abort && (r_state != ST_IDLE)) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_target <= i_target;
                        r_step   <= w_step_norm;
                        r_error  <= 1'b0;
                        r_abort  <= 1'b0;
                        r_state  <= (i_counter == i_target) ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    // A zero distance can only come from the datapath moving on its own;
                    // finishing here keeps the issued amount strictly positive.
                    if (w_abort_seen || (w_dist_t == '0)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_inc_valid  <= 1'b1;
                        r_inc_amount <= w_min_amt[SW-1:0];
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_handshake) begin
                        r_inc_valid <= 1'b0;
                        r_expected  <= i_counter + WIDTH'(r_inc_amount);
                        r_state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    r_magic_hit <= w_magic_eq;
                    if (i_counter != r_expected) begin
                        r_error <= 1'b1;
                        r_state <= ST_DONE;
                    end else if ((i_counter == r_target) || w_abort_seen) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    r_abort <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_inc.inc_valid  = r_inc_valid;
    assign if_inc.inc_amount = r_inc_amount;
    assign o_busy            = (r_state != ST_IDLE);
    assign o_done            = (r_state == ST_DONE);
    assign o_magic_hit       = r_magic_hit;
    assign o_error           = r_error;

endmodule

// File: tb/tb_demo_counter_step_ctrl.sv
// Directed bench for the demo counter step sequencer with a small counter datapath model.
module tb_demo_counter_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [19:0] target;
    logic [4:0]  step_req;
    logic [19:0] counter;
    logic        load;
    logic [19:0] load_val;
    logic        fault_add;
    logic        busy;
    logic        done;
    logic [3:0]  magic_hit;
    logic        error;

    int          n_checks = 0;
    int          n_errors = 0;
    int          amt_q[$];
    logic [3:0]  magic_acc;
    int          magic_pulses;
    int          first_valid;
    int          done_at;

    always #5 clk = ~clk;

    demo_counter_step_ctrl_if #(.SW(5)) inc_if ();

    demo_counter_step_ctrl dut (
        .i_clock     (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_target    (target),
        .i_step_req  (step_req),
        .i_abort     (abort),
        .i_counter   (counter),
        .if_inc      (inc_if),
        .o_busy      (busy),
        .o_done      (done),
        .o_magic_hit (magic_hit),
        .o_error     (error)
    );

    // Counter datapath model; fault_add makes it overshoot by one.
    always @(posedge clk) begin
        if (load) begin
            counter <= load_val;
        end else if (inc_if.inc_valid && inc_if.inc_ready) begin
            counter <= counter + 20'(inc_if.inc_amount) + 20'(fault_add);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int amt_at(input int i);
        return (i < amt_q.size()) ? amt_q[i] : -1;
    endfunction

    task automatic load_counter(input logic [19:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Pulse start for one edge; returns at the negedge after the start is sampled.
    task automatic kick(input logic [19:0] tgt, input logic [4:0] st);
        start        = 1'b1;
        target       = tgt;
        step_req     = st;
        amt_q.delete();
        magic_acc    = 4'b0;
        magic_pulses = 0;
        first_valid  = -1;
        done_at      = -1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (inc_if.inc_valid && (first_valid < 0)) first_valid = c;
            if (inc_if.inc_valid && inc_if.inc_ready) begin
                amt_q.push_back(int'(inc_if.inc_amount));
                $display("%s: increment %0d from counter %0d", tag, inc_if.inc_amount, counter);
            end
            if (magic_hit != 4'b0) begin
                magic_acc = magic_acc | magic_hit;
                magic_pulses++;
            end
            if (done) begin
                got     = 1'b1;
                done_at = c;
                break;
            end
            @(negedge clk);
        end
        check_val({tag, " done"}, 32'(got), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; target = '0; step_req = '0;
        load = 1'b0; load_val = '0; fault_add = 1'b0; inc_if.inc_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst busy", 32'(busy), 0);
        check_val("rst done", 32'(done), 0);
        check_val("rst valid", 32'(inc_if.inc_valid), 0);
        check_val("rst amount", 32'(inc_if.inc_amount), 0);
        check_val("rst magic", 32'(magic_hit), 0);
        check_val("rst error", 32'(error), 0);
        reset = 1'b0;

        // 1: landing on MAGIC[0]
        load_counter(20'd123450);
        kick(20'd123460, 5'd16);
        wait_done("t1");
        check_val("t1 count", 32'(amt_q.size()), 2);
        check_val("t1 amt0", 32'(amt_at(0)), 6);
        check_val("t1 amt1", 32'(amt_at(1)), 4);
        check_val("t1 latency", 32'(first_valid), 1);
        check_val("t1 magic", 32'(magic_acc), 32'b0001);
        check_val("t1 magic pulses", 32'(magic_pulses), 1);
        @(negedge clk);
        check_val("t1 busy after", 32'(busy), 0);
        check_val("t1 done after", 32'(done), 0);
        check_val("t1 counter", 32'(counter), 123460);

        // 2: wrap through the maximum
        load_counter(20'hffff8);
        kick(20'd3, 5'd16);
        wait_done("t2");
        check_val("t2 count", 32'(amt_q.size()), 3);
        check_val("t2 amt0", 32'(amt_at(0)), 7);
        check_val("t2 amt1", 32'(amt_at(1)), 1);
        check_val("t2 amt2", 32'(amt_at(2)), 3);
        check_val("t2 error", 32'(error), 0);
        check_val("t2 magic", 32'(magic_acc), 0);
        check_val("t2 counter", 32'(counter), 3);

        // 3: back-pressure holds the request stable
        inc_if.inc_ready = 1'b0;
        load_counter(20'd1000);
        kick(20'd1010, 5'd4);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_val("t3 valid held", 32'(inc_if.inc_valid), 1);
            check_val("t3 amount held", 32'(inc_if.inc_amount), 4);
            check_val("t3 counter held", 32'(counter), 1000);
            @(negedge clk);
        end
        inc_if.inc_ready = 1'b1;
        wait_done("t3");
        check_val("t3 count", 32'(amt_q.size()), 3);
        check_val("t3 amt2", 32'(amt_at(2)), 2);
        check_val("t3 counter", 32'(counter), 1010);

        // 4: datapath overshoot sets a sticky error
        fault_add = 1'b1;
        load_counter(20'd100);
        kick(20'd101, 5'd16);
        wait_done("t4");
        fault_add = 1'b0;
        check_val("t4 error", 32'(error), 1);
        check_val("t4 count", 32'(amt_q.size()), 1);
        @(negedge clk);
        check_val("t4 busy", 32'(busy), 0);
        check_val("t4 error sticky", 32'(error), 1);
        kick(20'd102, 5'd16);
        check_val("t4 error cleared", 32'(error), 0);
        wait_done("t4b");

        // 5: already at target, then minimum and clamped step sizes
        load_counter(20'd500);
        kick(20'd500, 5'd16);
        wait_done("t5");
        check_val("t5 done latency", 32'(done_at), 0);
        check_val("t5 no valid", 32'(first_valid), 32'hffffffff);
        load_counter(20'd600);
        kick(20'd603, 5'd0);
        wait_done("t5b");
        check_val("t5b count", 32'(amt_q.size()), 3);
        check_val("t5b amt0", 32'(amt_at(0)), 1);
        check_val("t5b amt2", 32'(amt_at(2)), 1);
        load_counter(20'd700);
        kick(20'd740, 5'd31);
        wait_done("t5c");
        check_val("t5c amt0", 32'(amt_at(0)), 16);
        check_val("t5c amt2", 32'(amt_at(2)), 8);

        // 6a: reset while waiting in ISSUE
        inc_if.inc_ready = 1'b0;
        load_counter(20'd2000);
        kick(20'd2010, 5'd16);
        @(negedge clk);
        check_val("t6 valid before reset", 32'(inc_if.inc_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        check_val("t6 valid", 32'(inc_if.inc_valid), 0);
        check_val("t6 amount", 32'(inc_if.inc_amount), 0);
        check_val("t6 busy", 32'(busy), 0);
        check_val("t6 done", 32'(done), 0);
        check_val("t6 error", 32'(error), 0);
        reset = 1'b0;
        inc_if.inc_ready = 1'b1;
        @(negedge clk);
        check_val("t6 counter", 32'(counter), 2000);

        // 6b: abort while waiting in ISSUE lets the handshake finish
        inc_if.inc_ready = 1'b0;
        load_counter(20'd3000);
        kick(20'd3100, 5'd16);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("t6b valid kept", 32'(inc_if.inc_valid), 1);
        check_val("t6b amount", 32'(inc_if.inc_amount), 16);
        inc_if.inc_ready = 1'b1;
        wait_done("t6b");
        check_val("t6b count", 32'(amt_q.size()), 1);
        check_val("t6b counter", 32'(counter), 3016);
        check_val("t6b error", 32'(error), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
